// File: rtl/tmax_gamma_n_if.sv
// Bus bundle for tmax_gamma_n: spike inputs, channel mask and windowed max results.
// TMAX_MIN_MODE_EN adds the first-arrival (min) outputs.
interface tmax_gamma_n_if #(
  parameter int N_IN  = 4,
  parameter int CNT_W = 4
);
  logic [N_IN-1:0]  a;
  logic [N_IN-1:0]  ch_mask;
  logic             gamma_start;
  logic             y;
  logic             y_valid;
  logic [CNT_W-1:0] y_time;
  logic             y_inf;
`ifdef TMAX_MIN_MODE_EN
  logic             y_min;
  logic [CNT_W-1:0] y_min_time;

  modport master (output a, ch_mask,
                  input  gamma_start, y, y_valid, y_time, y_inf, y_min, y_min_time);
  modport slave  (input  a, ch_mask,
                  output gamma_start, y, y_valid, y_time, y_inf, y_min, y_min_time);
`else
  modport master (output a, ch_mask,
                  input  gamma_start, y, y_valid, y_time, y_inf);
  modport slave  (input  a, ch_mask,
                  output gamma_start, y, y_valid, y_time, y_inf);
`endif
endinterface

// File: rtl/tmax_gamma_n.sv
// N-input temporal max (last arrival) with internal gamma window framing.
// Optional TMAX_MIN_MODE_EN builds the first-arrival (min) result alongside the max.
module tmax_gamma_n #(
  parameter int N_IN      = 4,
  parameter int GAMMA_LEN = 16,
  parameter int CNT_W     = $clog2(GAMMA_LEN)
) (
  input logic          aclk,
  input logic          grst,
  tmax_gamma_n_if.slave bus
);

  typedef enum logic {COLLECT, FIRED} state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  tmax, tmax_nx;
  logic [N_IN-1:0]   a_q, arrived, arrived_nx, mask_q, mask_eff, new_arr;
  logic              last, complete, fired_nx;
  logic              y_valid_r, y_inf_r;
  logic [CNT_W-1:0]  y_time_r;

  assign last = (count == CNT_W'(GAMMA_LEN - 1));

  // At count 0 the freshly sampled mask governs, so t=0 arrivals count.
  assign mask_eff   = (count == '0) ? bus.ch_mask : mask_q;
  assign new_arr    = bus.a & ~a_q & mask_eff & ~arrived;
  assign arrived_nx = arrived | new_arr;
  assign complete   = (state == COLLECT) && (|mask_eff) &&
                      ((arrived_nx & mask_eff) == mask_eff);

  always_comb begin
    state_nx = state;
    tmax_nx  = tmax;
    case (state)
      COLLECT: if (complete) state_nx = FIRED;
      FIRED:   state_nx = FIRED;
      default: state_nx = COLLECT;
    endcase
    if (complete) tmax_nx = count;
    // Report what the window reached (including a t=GAMMA_LEN-1 completion) before the wrap clears it.
    fired_nx = (state_nx == FIRED);
    if (last) state_nx = COLLECT;
  end

  always_ff @(posedge aclk or negedge grst) begin
    if (!grst) begin
      state     <= COLLECT;
      count     <= '0;
      a_q       <= '0;
      arrived   <= '0;
      mask_q    <= '0;
      tmax      <= '0;
      y_valid_r <= 1'b0;
      y_time_r  <= '0;
      y_inf_r   <= 1'b0;
    end else begin
      state     <= state_nx;
      count     <= last ? '0 : count + CNT_W'(1);
      a_q       <= bus.a;
      if (count == '0) mask_q <= bus.ch_mask;
      arrived   <= last ? '0 : arrived_nx;
      tmax      <= last ? '0 : tmax_nx;
      y_valid_r <= last;
      if (last) begin
        y_time_r <= fired_nx ? tmax_nx : '0;
        y_inf_r  <= ~fired_nx;
      end
    end
  end

  assign bus.gamma_start = (count == '0);
  assign bus.y           = (state == FIRED);
  assign bus.y_valid     = y_valid_r;
  assign bus.y_time      = y_time_r;
  assign bus.y_inf       = y_inf_r;

`ifdef TMAX_MIN_MODE_EN
  logic             min_seen, min_seen_nx;
  logic [CNT_W-1:0] tmin, tmin_nx, y_min_time_r;

  always_comb begin
    min_seen_nx = min_seen | (|new_arr);
    tmin_nx     = tmin;
    if (!min_seen && (|new_arr)) tmin_nx = count;
  end

  always_ff @(posedge aclk or negedge grst) begin
    if (!grst) begin
      min_seen     <= 1'b0;
      tmin         <= '0;
      y_min_time_r <= '0;
    end else begin
      min_seen <= last ? 1'b0 : min_seen_nx;
      tmin     <= last ? '0 : tmin_nx;
      if (last) y_min_time_r <= min_seen_nx ? tmin_nx : '0;
    end
  end

  assign bus.y_min      = min_seen;
  assign bus.y_min_time = y_min_time_r;
`endif

endmodule

// File: tb/tb_tmax_gamma_n.sv
// Directed bench for tmax_gamma_n (N_IN=4, GAMMA_LEN=16); checks y/y_valid/y_time/y_inf
// per cycle, plus y_min/y_min_time when TMAX_MIN_MODE_EN is defined.
module tb_tmax_gamma_n;
  localparam int N = 4;
  localparam int G = 16;
  localparam int W = 4;
  localparam int NONE = 16;

  logic aclk = 1'b0;
  logic grst = 1'b0;
  always #5 aclk = ~aclk;

  tmax_gamma_n_if #(.N_IN(N), .CNT_W(W)) bus ();
  tmax_gamma_n #(.N_IN(N), .GAMMA_LEN(G), .CNT_W(W)) dut (
    .aclk(aclk),
    .grst(grst),
    .bus (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  logic         pend_valid = 1'b0;
  logic [W-1:0] pend_time  = '0;
  logic         pend_inf   = 1'b0;
`ifdef TMAX_MIN_MODE_EN
  logic [W-1:0] pend_min   = '0;
`endif

  // One gamma window. Edge times of NONE mean no edge; lvl keeps a channel high from its
  // edge to the window end, pre holds it high all window. rst_t aborts the window with a reset.
  task automatic run_window(input string name, input int e0, input int e1, input int e2,
                            input int e3, input logic [3:0] lvl, input logic [3:0] pre,
                            input logic [3:0] mask, input logic [3:0] late_mask,
                            input int late_t, input bit exp_fire, input int exp_tmax,
                            input int exp_min, input int rst_t);
    int e [4];
    logic [3:0] a_n;
    logic exp_yv, exp_y;
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    for (int t = 0; t < G; t++) begin
      vectors++;
      if (bus.gamma_start !== (t == 0))
        $display("FAIL %s t=%0d gamma_start: got %b want %b", name, t, bus.gamma_start, (t == 0));
      exp_yv = (t == 0) && pend_valid;
      vectors++;
      if (bus.y_valid !== exp_yv)
        $display("FAIL %s t=%0d y_valid: got %b want %b", name, t, bus.y_valid, exp_yv);
      if (exp_yv) begin
        vectors++;
        if (bus.y_time !== pend_time) begin
          miscompares++;
          $display("FAIL %s report y_time: got %0d want %0d", name, bus.y_time, pend_time);
        end
        vectors++;
        if (bus.y_inf !== pend_inf) begin
          miscompares++;
          $display("FAIL %s report y_inf: got %b want %b", name, bus.y_inf, pend_inf);
        end
`ifdef TMAX_MIN_MODE_EN
        vectors++;
        if (bus.y_min_time !== pend_min) begin
          miscompares++;
          $display("FAIL %s report y_min_time: got %0d want %0d", name, bus.y_min_time, pend_min);
        end
`endif
      end
      if (bus.gamma_start !== (t == 0)) miscompares++;
      if (bus.y_valid !== exp_yv) miscompares++;
      exp_y = exp_fire && (t > exp_tmax);
      vectors++;
      if (bus.y !== exp_y) begin
        miscompares++;
        $display("FAIL %s t=%0d y: got %b want %b", name, t, bus.y, exp_y);
      end
`ifdef TMAX_MIN_MODE_EN
      vectors++;
      if (bus.y_min !== (t > exp_min)) begin
        miscompares++;
        $display("FAIL %s t=%0d y_min: got %b want %b", name, t, bus.y_min, (t > exp_min));
      end
`endif
      for (int i = 0; i < N; i++)
        a_n[i] = pre[i] | (lvl[i] ? (t >= e[i]) : (t == e[i]));
      bus.a       = a_n;
      bus.ch_mask = (t >= late_t) ? late_mask : mask;
      if (t == rst_t) begin
        #2 grst = 1'b0;
        bus.a = '0;
        #1;
        vectors++;
        if ({bus.y, bus.y_valid, bus.y_inf, bus.y_time} !== '0) begin
          miscompares++;
          $display("FAIL %s async reset outputs: got y=%b yv=%b inf=%b time=%0d want all 0",
                   name, bus.y, bus.y_valid, bus.y_inf, bus.y_time);
        end
        vectors++;
        if (bus.gamma_start !== 1'b1) begin
          miscompares++;
          $display("FAIL %s async reset gamma_start: got %b want 1", name, bus.gamma_start);
        end
`ifdef TMAX_MIN_MODE_EN
        vectors++;
        if ({bus.y_min, bus.y_min_time} !== '0) begin
          miscompares++;
          $display("FAIL %s async reset min outputs: got %b/%0d want 0/0", name, bus.y_min, bus.y_min_time);
        end
`endif
        @(posedge aclk);
        #1 grst = 1'b1;
        pend_valid = 1'b0;
        return;
      end
      @(posedge aclk);
      #1;
    end
    pend_valid = 1'b1;
    pend_time  = exp_fire ? W'(exp_tmax) : '0;
    pend_inf   = ~exp_fire;
`ifdef TMAX_MIN_MODE_EN
    pend_min   = (exp_min < G) ? W'(exp_min) : '0;
`endif
  endtask

  task automatic test_reset();
    bus.a = '0;
    bus.ch_mask = 4'b1111;
    #12;
    vectors++;
    if ({bus.y, bus.y_valid, bus.y_inf, bus.y_time} !== '0) begin
      miscompares++;
      $display("FAIL reset outputs: got y=%b yv=%b inf=%b time=%0d want all 0",
               bus.y, bus.y_valid, bus.y_inf, bus.y_time);
    end
    vectors++;
    if (bus.gamma_start !== 1'b1) begin
      miscompares++;
      $display("FAIL reset gamma_start: got %b want 1", bus.gamma_start);
    end
    @(posedge aclk);
    #1 grst = 1'b1;
  endtask

  task automatic test_basic();
    run_window("basic", 2, 5, 9, 3, 4'b0000, 4'b0000, 4'b1111, 4'b1111, NONE, 1'b1, 9, 2, NONE);
  endtask

  task automatic test_simultaneous_and_hold();
    run_window("simul", 4, 4, 4, 4, 4'b0001, 4'b0000, 4'b1111, 4'b1111, NONE, 1'b1, 4, 4, NONE);
    run_window("held_a0", NONE, 4, 4, 4, 4'b0000, 4'b0001, 4'b1111, 4'b1111, NONE, 1'b0, 0, 4, NONE);
  endtask

  task automatic test_mask();
    run_window("mask0101", 3, 10, 7, NONE, 4'b0000, 4'b0000, 4'b0101, 4'b1111, 8, 1'b1, 7, 3, NONE);
  endtask

  task automatic test_incomplete();
    run_window("a3_silent", 1, 2, 3, NONE, 4'b0000, 4'b0000, 4'b1111, 4'b1111, NONE, 1'b0, 0, 1, NONE);
    run_window("mask_zero", 2, 2, 2, 2, 4'b0000, 4'b0000, 4'b0000, 4'b0000, NONE, 1'b0, 0, NONE, NONE);
  endtask

  task automatic test_t0_arrival();
    run_window("t0", 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b1111, 4'b1111, NONE, 1'b1, 0, 0, NONE);
  endtask

  task automatic test_late_and_reset();
    run_window("last_t15", 1, 4, 8, 15, 4'b0000, 4'b0000, 4'b1111, 4'b1111, NONE, 1'b1, 15, 1, NONE);
    run_window("mid_reset", 1, 1, 1, 1, 4'b0000, 4'b0000, 4'b1111, 4'b1111, NONE, 1'b1, 1, 1, 6);
    run_window("post_reset", 3, 6, 2, 10, 4'b0000, 4'b0000, 4'b1111, 4'b1111, NONE, 1'b1, 10, 2, NONE);
    run_window("flush", NONE, NONE, NONE, NONE, 4'b0000, 4'b0000, 4'b1111, 4'b1111, NONE, 1'b0, 0, NONE, NONE);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_simultaneous_and_hold();
    test_mask();
    test_incomplete();
    test_t0_arrival();
    test_late_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/tmax_gamma_n.md
Name: tmax_gamma_n

Overview:
- N-input temporal max (race-logic "last arrival") primitive with internal gamma framing.
- Time is divided into gamma windows of GAMMA_LEN aclk cycles.
- Each enabled input contributes one rising edge per window, and the edge time is the value.
- y rises one cycle after the latest enabled arrival and holds until window end, so its pulse width encodes the max. The arrival time is also reported as a binary value at window end.
- Used as the aggregation stage after column neurons in the temporal network datapath.

Parameters:
N_IN, 4, number of input channels (>=2)
GAMMA_LEN, 16, aclk cycles per gamma window (>=4, need not be a power of 2)
CNT_W, $clog2(GAMMA_LEN), width of the in-window time counter and result

Ports:
aclk  input  1  clock, all state on rising edge
grst  input  1  reset, asynchronous, active-low
a  input  N_IN  temporal spike inputs; rising edge marks arrival
ch_mask  input  N_IN  1 = channel enabled; sampled once at window start (count==0)
gamma_start  output  1  high while count==0 (first cycle of each window)
y  output  1  pulse-width max output
y_valid  output  1  one-cycle strobe at window start reporting the previous window
y_time  output  CNT_W  arrival time of latest enabled input in previous window
y_inf  output  1  with y_valid: no result (not all enabled inputs arrived, or mask all zero)

Behaviour:
- Reset (grst low, async): count=0; a_q=0; arrived=0; mask_q=0; fired=0; tmax=0; y=0; y_valid=0; y_time=0; y_inf=0.
- On release, the first window starts at count 0. gamma_start is a decode of count==0, so it is high in the first cycle. The first y_valid occurs at the first wrap, not at release.
- Counter: count increments each cycle and wraps from GAMMA_LEN-1 to 0.
- Edge detect: a_q <= a every cycle. rise[i] = a[i] & ~a_q[i].
  - A level held high across a window boundary is not a new arrival.
- mask_q <= ch_mask when count==0. Changes to ch_mask mid-window are ignored.
- Arrival: at a posedge with count==t, a rise on an enabled, not-yet-arrived channel sets arrived[i].
  - When this completes the enabled set (all mask_q bits arrived, mask_q nonzero), set fired=1 and tmax=t.
  - Duplicate edges on a channel are ignored. Simultaneous edges are counted in the same cycle.
  - At count==0, mask_q in use is the newly sampled ch_mask, so arrivals at t=0 are valid.
- Per-window state machine:
  - COLLECT: waiting for the enabled set to complete.
  - FIRED: y=1 from the cycle after completion until the window end (registered, 1-cycle latency).
  - Wrap (count==GAMMA_LEN-1 -> 0), from either state:
    - Clear arrived and fired.
    - Drop y to 0 at count 0.
    - Pulse y_valid for one cycle, with y_time=tmax and y_inf=~fired.
    - If ~fired, y_time=0.
- Width rule: y is high for GAMMA_LEN-1-tmax cycles.
- Arrival completing at t=GAMMA_LEN-1: fired is set, y_valid reports y_time=GAMMA_LEN-1, y_inf=0, and y is never asserted (width 0).
- mask_q==0: the window never fires; y_inf=1.
- Reset mid-window: everything clears immediately. Partial window results are discarded, and no y_valid is generated for that window.

Optional Feature:
- Macro: TMAX_MIN_MODE_EN.
- Defined:
  - Add output y_min (1 bit) and y_min_time (CNT_W bits), valid with y_valid.
  - y_min rises the cycle after the first enabled arrival and holds until window end.
  - y_min_time is the earliest enabled arrival time (0 if none).
  - y_inf is unchanged: it reflects the max only.
- Undefined: these ports do not exist and no first-arrival logic is built.

Test Plan (N_IN=4, GAMMA_LEN=16, ch_mask=4'b1111 unless stated):
1. Edges a0@t=2, a1@t=5, a2@t=9, a3@t=3 -> y high t=10..15 (6 cycles); next window count 0: y_valid=1, y_time=9, y_inf=0.
2. All four rise together @t=4 -> y high t=5..15; y_time=4. Repeat with a0 held high across the boundary and no new edge -> y_inf=1 next report.
3. ch_mask=4'b0101; a0@t=3, a2@t=7, a1/a3 never rise -> y_time=7, y_inf=0. ch_mask changed to 4'b1111 at t=8 -> no effect this window.
4. Only a0..a2 rise (a3 silent) -> y stays 0, y_valid with y_inf=1, y_time=0. ch_mask=0 -> y_inf=1.
5. Last arrival @t=15 -> y never high; y_time=15, y_inf=0. Assert grst low at t=6 of a later window -> all outputs 0 asynchronously; after release no y_valid until the first wrap.
6. (TMAX_MIN_MODE_EN) Scenario 1 stimulus -> y_min high t=3..15, y_min_time=2.
